// File: rtl/block_check_seq.sv
// Store-and-forward sequencer: buffers one framed character stream, resets the
// begin/end checker, replays the frame gap-free and returns the sampled verdict.
module block_check_seq #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             chk_reset,
  output logic [7:0]       chk_char,
  input  logic             chk_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_pass,
  output logic             res_ovf,
  output logic [LEN_W-1:0] res_len
);

  localparam int               AW    = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] FULL  = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);
  localparam logic [7:0]       SPACE = 8'h20;

  typedef enum logic [2:0] {LOAD, CLEAR, FEED, WAIT, REPORT} state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] rd;
  logic             ovf;
  logic             clr;
  logic             accept;
  logic             store;

  assign accept    = in_valid & in_ready;
  assign store     = accept & (count != FULL);
  assign chk_reset = ~reset | clr;

  always_ff @(posedge clk) begin
    if (store) mem[count[AW-1:0]] <= in_char;
  end

  // rd holds the index of the character to present on the next FEED cycle,
  // so chk_char can be registered while still streaming without bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      count     <= '0;
      rd        <= '0;
      ovf       <= 1'b0;
      clr       <= 1'b0;
      in_ready  <= 1'b1;
      chk_char  <= SPACE;
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      res_ovf   <= 1'b0;
      res_len   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (count != FULL) count <= count + ONE;
            else               ovf   <= 1'b1;
            if (in_last) begin
              state    <= CLEAR;
              in_ready <= 1'b0;
              clr      <= 1'b1;
            end
          end
        end
        CLEAR: begin
          clr      <= 1'b0;
          rd       <= ONE;
          chk_char <= mem[0];
          state    <= FEED;
        end
        FEED: begin
          if (rd == count) begin
            chk_char <= SPACE;
            state    <= WAIT;
          end else begin
            chk_char <= mem[rd[AW-1:0]];
            rd       <= rd + ONE;
          end
        end
        WAIT: begin
          res_pass  <= chk_result & ~ovf;
          res_ovf   <= ovf;
          res_len   <= count;
          res_valid <= 1'b1;
          state     <= REPORT;
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_block_check_seq.sv
// Bench for block_check_seq: behavioural begin/end checker, frame-level reference
// model and a scoreboard monitor on replay timing and the result port.
module tb_block_check_seq;

  localparam int DEPTH = 16;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_char = 8'h00;
  logic             in_last = 1'b0;
  logic             chk_reset;
  logic [7:0]       chk_char;
  logic             chk_result;
  logic             res_valid;
  logic             res_ready;
  logic             res_pass;
  logic             res_ovf;
  logic [LEN_W-1:0] res_len;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_mode = 0;

  typedef struct {
    bit    pass;
    bit    ovf;
    int    len;
    string replay;
  } exp_t;

  exp_t exp_q[$];

  block_check_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
    .chk_reset(chk_reset), .chk_char(chk_char), .chk_result(chk_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_pass(res_pass), .res_ovf(res_ovf), .res_len(res_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Behavioural checker: words are runs of non-space chars; the live result
  // treats the word in progress as if it had just been terminated.
  int          ck_depth, ck_nd, ck_pd, ck_wlen, ck_nl;
  logic        ck_under, ck_nu, ck_pu, ck_nres;
  logic [39:0] ck_word, ck_nw;
  logic [7:0]  ck_lc;

  function automatic int word_kind(input int len, input logic [39:0] w);
    if (len == 5 && w == "begin") return 1;
    if (len == 3 && w[23:0] == "end") return -1;
    return 0;
  endfunction

  always_comb begin
    ck_nd = ck_depth;
    ck_nu = ck_under;
    ck_nl = ck_wlen;
    ck_nw = ck_word;
    ck_lc = chk_char;
    if (chk_char >= "A" && chk_char <= "Z") ck_lc = chk_char + 8'd32;
    if (chk_char == " ") begin
      case (word_kind(ck_wlen, ck_word))
        1:       ck_nd = ck_depth + 1;
        -1:      if (ck_depth == 0) ck_nu = 1'b1; else ck_nd = ck_depth - 1;
        default: ;
      endcase
      ck_nl = 0;
      ck_nw = '0;
    end else begin
      ck_nw = {ck_word[31:0], ck_lc};
      ck_nl = (ck_wlen < 6) ? ck_wlen + 1 : 6;
    end
    ck_pd = ck_nd;
    ck_pu = ck_nu;
    case (word_kind(ck_nl, ck_nw))
      1:       ck_pd = ck_nd + 1;
      -1:      if (ck_nd == 0) ck_pu = 1'b1; else ck_pd = ck_nd - 1;
      default: ;
    endcase
    ck_nres = (ck_pd == 0) && !ck_pu;
  end

  always @(posedge clk) begin
    if (chk_reset) begin
      ck_depth   <= 0;
      ck_under   <= 1'b0;
      ck_wlen    <= 0;
      ck_word    <= '0;
      chk_result <= 1'b1;
    end else begin
      ck_depth   <= ck_nd;
      ck_under   <= ck_nu;
      ck_wlen    <= ck_nl;
      ck_word    <= ck_nw;
      chk_result <= ck_nres;
    end
  end

  // Frame-level reference: split on spaces, count nesting over the whole string.
  function automatic bit ref_balanced(input string t);
    int    depth = 0;
    bit    bad = 0;
    string w = "";
    for (int i = 0; i <= t.len(); i++) begin
      if (i == t.len() || t[i] == " ") begin
        w = w.tolower();
        if (w == "begin") depth++;
        else if (w == "end") begin
          if (depth == 0) bad = 1;
          else depth--;
        end
        w = "";
      end else begin
        w = {w, t.substr(i, i)};
      end
    end
    return !bad && depth == 0;
  endfunction

  function automatic string rand_frame(input int len);
    string toks[6] = '{"begin ", "end ", "BEGIN ", "End ", "  ", "xy "};
    string s = "";
    while (s.len() < len) s = {s, toks[$urandom_range(0, 5)]};
    return s.substr(0, len - 1);
  endfunction

  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'b0;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // gap: 0 none, 1 bubble before every char, 2 random bubbles
  task automatic send_frame(input string s, input int gap);
    exp_t e;
    int   n;
    e.len    = (s.len() > DEPTH) ? DEPTH : s.len();
    e.ovf    = (s.len() > DEPTH);
    e.replay = s.substr(0, e.len - 1);
    e.pass   = !e.ovf && ref_balanced(e.replay);
    exp_q.push_back(e);
    for (int i = 0; i < s.len(); i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_char  = s[i];
      in_last  = (i == s.len() - 1);
      if (i > 0) chk("in_ready_mid_frame", in_ready, 1);
      n = 0;
      while (!in_ready && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("in_ready_timeout", in_ready, 1);
      if (!in_ready) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : monitor
    int               pos;
    exp_t             cur;
    exp_t             e;
    bit               snap;
    logic             sp, so;
    logic [LEN_W-1:0] sl;
    pos  = -1;
    snap = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("chk_reset_in_reset", chk_reset, 1);
        chk("res_valid_in_reset", res_valid, 0);
        pos  = -1;
        snap = 1'b0;
      end else begin
        if (pos < 0) begin
          if (chk_reset) begin
            if (exp_q.size() == 0) fail_msg("clear_without_frame");
            else begin
              cur = exp_q[0];
              pos = 0;
            end
          end else begin
            chk("idle_space", chk_char, 8'h20);
          end
        end else begin
          pos++;
          if (pos == 1) chk("clear_one_cycle", chk_reset, 0);
          if (pos <= cur.len) begin
            chk("replay_char", chk_char, cur.replay[pos-1]);
            chk("valid_during_feed", res_valid, 0);
          end else if (pos == cur.len + 1) begin
            chk("wait_space", chk_char, 8'h20);
            chk("valid_during_wait", res_valid, 0);
          end else begin
            chk("res_valid_latency", res_valid, 1);
            pos = -1;
          end
        end
        if (res_valid) begin
          chk("in_ready_report", in_ready, 0);
          if (snap) begin
            chk("hold_pass", res_pass, sp);
            chk("hold_ovf", res_ovf, so);
            chk("hold_len", res_len, sl);
          end else begin
            snap = 1'b1;
            sp   = res_pass;
            so   = res_ovf;
            sl   = res_len;
          end
          if (res_ready) begin
            if (exp_q.size() == 0) fail_msg("unexpected_result");
            else begin
              e = exp_q.pop_front();
              chk("res_pass", res_pass, e.pass);
              chk("res_ovf", res_ovf, e.ovf);
              chk("res_len", res_len, e.len);
            end
            snap = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_chk_reset", chk_reset, 1);
    chk("rst_chk_char", chk_char, 8'h20);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_pass", res_pass, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_res_len", res_len, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_chk_reset", chk_reset, 0);

    send_frame("begin end", 0);
    wait_idle();
    send_frame("end begin", 0);
    send_frame("BEGIN END", 0);
    wait_idle();
    send_frame("begin", 1);
    wait_idle();
    send_frame("begin begin end end ", 0);
    wait_idle();
    send_frame("  begin     end ", 0);
    send_frame("  begin     end e", 2);
    send_frame("x", 0);
    wait_idle();

    // result backpressure
    rr_mode = 1;
    send_frame("begin end", 0);
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_seen", res_valid, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid_held", res_valid, 1);
    chk("bp_in_ready_low", in_ready, 0);
    rr_mode = 0;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_valid_after", res_valid, 0);
    wait_idle();

    // reset during replay
    send_frame("begin end", 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_chk_reset", chk_reset, 1);
    chk("midrst_res_valid", res_valid, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 1);
    send_frame("end", 0);
    wait_idle();

    rr_mode = 2;
    for (int k = 0; k < 30; k++) begin
      send_frame(rand_frame($urandom_range(1, 20)), 2);
    end
    wait_idle();
    rr_mode = 0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_check_seq.md
Name: block_check_seq

Overview:
- Store-and-forward sequencer for the begin/end nesting checker (active-high reset, one character per clock, live `result` output).
- Buffers one framed character stream from an upstream valid/ready source, clears the checker, then replays the frame into it back-to-back.
- The checker has no enable, so replay must be gap-free; this block guarantees that, then samples the verdict and returns it through a valid/ready result port.
- Sits between the character source and the checker.

Parameters:
- DEPTH, 16, frame buffer capacity in characters; power of two, ≥2.
- LEN_W, 5, width of length counters; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream character valid.
- in_ready  output  1  block accepts a character this cycle.
- in_char  input  8  ASCII character.
- in_last  input  1  marks the final character of a frame; every frame is ≥1 char.
- chk_reset  output  1  active-high reset to the checker.
- chk_char  output  8  character driven to the checker input.
- chk_result  input  1  checker `result` output (registered in the checker).
- res_valid  output  1  verdict available.
- res_ready  input  1  consumer takes the verdict.
- res_pass  output  1  1 = balanced and never underflowed; forced 0 on overflow.
- res_ovf  output  1  frame exceeded DEPTH chars; excess chars were discarded.
- res_len  output  LEN_W  number of chars stored and replayed, 1..DEPTH.

Behaviour:
- States: LOAD, CLEAR, FEED, WAIT, REPORT. Reset (reset=0, async) forces:
  - state = LOAD; wr/rd pointers = 0; ovf = 0.
  - res_valid = 0, res_pass = 0, res_ovf = 0, res_len = 0.
  - chk_char = 0x20; chk_reset = 1 (combinationally, for as long as reset=0).
- chk_char = 0x20 (space) in every state except FEED. Space after space is neutral for the checker, so the idle filler cannot corrupt its state.
- LOAD:
  - in_ready = 1.
  - Handshake = in_valid & in_ready.
  - While count < DEPTH, a handshake writes buf[count] and increments count.
  - A handshake at count == DEPTH discards the char and sets ovf.
  - A handshake with in_last = 1 goes to CLEAR, after the write or discard.
  - No frame is ever split across states.
- CLEAR: in_ready = 0; chk_reset = 1 for exactly one cycle; rd = 0; next state FEED.
- FEED:
  - chk_char = buf[rd] each cycle; rd increments.
  - Exactly count consecutive cycles, with no bubbles.
  - Next state WAIT after the cycle where rd == count-1.
- WAIT:
  - One cycle; chk_char = space.
  - Samples chk_result, which reflects the final fed character.
  - res_pass <= chk_result & ~ovf; res_ovf <= ovf; res_len <= count.
  - Next state REPORT.
- REPORT:
  - res_valid = 1; res_* held stable until res_valid & res_ready.
  - On that handshake: res_valid = 0, count = 0, ovf = 0, next state LOAD.
  - in_ready = 0 throughout; backpressure may last indefinitely.
- Latency: last char accepted in cycle T, so CLEAR = T+1, FEED = T+2..T+1+count, WAIT = T+2+count, res_valid first high at T+3+count.
- Throughput: while not in LOAD, in_ready = 0. No overlap of load and replay.
- Overflow: the first DEPTH chars are still replayed, so the checker sees a truncated frame. The verdict is forced fail with res_ovf = 1.
- Reset mid-operation (any state): immediate return to reset values. A partially loaded frame and a pending verdict are dropped.
- in_valid with in_ready = 0: ignored. The upstream source must hold its data.

Test Plan:
- "begin end" (9 chars, last on 'd'), res_ready=1 → CLEAR 1 cycle; chk_char sequence b,e,g,i,n,space,e,n,d on 9 consecutive cycles; res_valid at T+12 with res_pass=1, res_ovf=0, res_len=9.
- "end begin" → res_pass=0 (underflow latched by the checker), res_len=9; a following frame "BEGIN END" → res_pass=1, proving CLEAR wiped the previous flag.
- in_valid toggled 1/0 every cycle while loading "begin" → no chk_char activity until last accepted; replay still 5 consecutive cycles; res_pass=0 (unclosed), res_len=5.
- DEPTH=16, 20-char frame "begin begin end en" padded to 20 → in_ready stays 1 for all 20; res_ovf=1, res_pass=0, res_len=16; only 16 chars replayed.
- res_ready held 0 for 10 cycles in REPORT → res_valid/res_pass/res_len stable, in_ready=0; on res_ready=1 one handshake occurs, then in_ready=1 the next cycle.
- reset pulled low during FEED of "begin end" → chk_reset=1 immediately, res_valid=0, in_ready=1 after release; next frame "end" → res_pass=0, res_len=3.
